// File: rtl/imm_ext_pipe.sv
// Pipelined immediate extender with a two-entry skid buffer.
// Results leave in strict FIFO order through a registered output stage.
module imm_ext_pipe #(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_imm,
  input  logic [2:0]       in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic [2:0]       out_op,
  output logic             err
);

  localparam int Z = OUT_W - IN_W;

  logic             out_valid_q, out_valid_d;
  logic [OUT_W-1:0] out_data_q, out_data_d;
  logic [2:0]       out_op_q, out_op_d;
  logic             skid_valid_q, skid_valid_d;
  logic [OUT_W-1:0] skid_data_q, skid_data_d;
  logic [2:0]       skid_op_q, skid_op_d;
  logic             err_q, err_d;

  logic [OUT_W-1:0] zext, sext, res;
  logic             illegal;
  logic             accept, drain;

  assign zext = {{Z{1'b0}}, in_imm};
  assign sext = {{Z{in_imm[IN_W-1]}}, in_imm};

  always_comb begin
    res     = zext;
    illegal = 1'b0;
    unique case (in_op)
      3'b000:  res = zext;
      3'b001:  res = sext;
      3'b010:  res = {in_imm, {Z{1'b0}}};
      3'b011:  res = sext << 2;
      3'b100:  res = zext << 2;
      default: begin
        res     = zext;
        illegal = 1'b1;
      end
    endcase
  end

  // Ready depends only on skid occupancy, so no path from out_ready.
  assign in_ready = !skid_valid_q;
  assign accept   = in_valid && in_ready && !flush;
  assign drain    = out_valid_q && out_ready;

  always_comb begin
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    out_op_d     = out_op_q;
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;
    skid_op_d    = skid_op_q;
    err_d        = err_q;
    if (flush) begin
      out_valid_d  = 1'b0;
      skid_valid_d = 1'b0;
    end else begin
      if (drain) begin
        if (skid_valid_q) begin
          out_data_d   = skid_data_q;
          out_op_d     = skid_op_q;
          skid_valid_d = 1'b0;
        end else if (accept) begin
          out_data_d = res;
          out_op_d   = in_op;
        end else begin
          out_valid_d = 1'b0;
        end
      end else if (accept) begin
        if (!out_valid_q) begin
          out_valid_d = 1'b1;
          out_data_d  = res;
          out_op_d    = in_op;
        end else begin
          skid_valid_d = 1'b1;
          skid_data_d  = res;
          skid_op_d    = in_op;
        end
      end
      err_d = err_q | (accept & illegal);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_op_q     <= 3'b000;
      skid_valid_q <= 1'b0;
      skid_data_q  <= '0;
      skid_op_q    <= 3'b000;
      err_q        <= 1'b0;
    end else begin
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_op_q     <= out_op_d;
      skid_valid_q <= skid_valid_d;
      skid_data_q  <= skid_data_d;
      skid_op_q    <= skid_op_d;
      err_q        <= err_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_op    = out_op_q;
  assign err       = err_q;

endmodule

// File: tb/tb_imm_ext_pipe.sv
// Self-checking bench for imm_ext_pipe: directed cases plus random
// traffic checked against a queue-based reference model.
module tb_imm_ext_pipe;

  logic        clk = 1'b0;
  logic        reset, flush, in_valid, in_ready, out_valid, out_ready, err;
  logic [15:0] in_imm;
  logic [2:0]  in_op, out_op;
  logic [31:0] out_data;

  logic        reset2, flush2, in_valid2, in_ready2, out_valid2, out_ready2, err2;
  logic [11:0] in_imm2;
  logic [2:0]  in_op2, out_op2;
  logic [23:0] out_data2;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [31:0] data;
    logic [2:0]  op;
  } ent_t;

  ent_t q[$];
  logic err_m;
  bit   model_on;
  bit   rst_seen;

  always #5 clk = ~clk;

  imm_ext_pipe dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_imm(in_imm), .in_op(in_op),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_op(out_op), .err(err)
  );

  imm_ext_pipe #(.IN_W(12), .OUT_W(24)) dut2 (
    .clk(clk), .reset(reset2), .flush(flush2),
    .in_valid(in_valid2), .in_ready(in_ready2),
    .in_imm(in_imm2), .in_op(in_op2),
    .out_valid(out_valid2), .out_ready(out_ready2),
    .out_data(out_data2), .out_op(out_op2), .err(err2)
  );

  function automatic longint unsigned ref_ext(
    input int inw, input int outw,
    input longint unsigned imm, input logic [2:0] op);
    longint unsigned m, u, s, r;
    m = (64'd1 << outw) - 1;
    u = imm & ((64'd1 << inw) - 1);
    s = u;
    if (u >= (64'd1 << (inw - 1)))
      s = u + (m + 1) - (64'd1 << inw);
    case (op)
      3'd1: r = s;
      3'd2: r = u * (64'd1 << (outw - inw));
      3'd3: r = s * 4;
      3'd4: r = u * 4;
      default: r = u;
    endcase
    return r & m;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic v, input logic [15:0] imm,
                      input logic [2:0] op, input logic rdy,
                      input logic fl, input logic rs);
    bit acc;
    in_valid  = v;
    in_imm    = imm;
    in_op     = op;
    out_ready = rdy;
    flush     = fl;
    reset     = rs;
    @(negedge clk);
    if (model_on) begin
      chk("out_valid", out_valid, q.size() > 0);
      chk("in_ready", in_ready, q.size() < 2);
      chk("err", err, err_m);
      if (q.size() > 0) begin
        chk("out_data", out_data, q[0].data);
        chk("out_op", out_op, q[0].op);
      end else if (rst_seen) begin
        chk("rst_data", out_data, 0);
        chk("rst_op", out_op, 0);
      end
    end
    rst_seen = 0;
    if (rs) begin
      q.delete();
      err_m    = 0;
      model_on = 1;
      rst_seen = 1;
    end else if (fl) begin
      q.delete();
    end else begin
      acc = v && (q.size() < 2);
      if (q.size() > 0 && rdy) void'(q.pop_front());
      if (acc) begin
        q.push_back('{data: ref_ext(16, 32, imm, op), op: op});
        if (op >= 3'd5) err_m = 1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    model_on = 0;
    rst_seen = 0;
    err_m = 0;
    reset2 = 1; flush2 = 0; in_valid2 = 0;
    in_imm2 = '0; in_op2 = '0; out_ready2 = 1;

    step(0, 0, 0, 1, 0, 1);
    step(0, 0, 0, 1, 0, 1);
    chk("reset_ready", in_ready, 1);
    chk("reset_valid", out_valid, 0);

    step(1, 16'h8001, 3'd0, 1, 0, 0);
    chk("zext", out_data, 32'h00008001);
    step(1, 16'h8001, 3'd1, 1, 0, 0);
    chk("sext", out_data, 32'hFFFF8001);
    step(1, 16'h8001, 3'd2, 1, 0, 0);
    chk("upper", out_data, 32'h80010000);
    step(1, 16'hFFFF, 3'd3, 1, 0, 0);
    chk("branch", out_data, 32'hFFFFFFFC);
    step(1, 16'hFFFF, 3'd4, 1, 0, 0);
    chk("zshl2", out_data, 32'h0003FFFC);
    step(0, 0, 0, 1, 0, 0);

    step(1, 16'h0001, 3'd0, 0, 0, 0);
    step(1, 16'h0002, 3'd0, 0, 0, 0);
    chk("bp_full", in_ready, 0);
    step(1, 16'h0003, 3'd0, 0, 0, 0);
    chk("bp_hold", out_data, 32'h1);
    step(1, 16'h0003, 3'd0, 1, 0, 0);
    chk("bp_second", out_data, 32'h2);
    chk("bp_ready", in_ready, 1);
    step(1, 16'h0003, 3'd0, 1, 0, 0);
    chk("bp_third", out_data, 32'h3);
    step(0, 0, 0, 1, 0, 0);

    step(1, 16'h1234, 3'd6, 1, 0, 0);
    chk("illegal_data", out_data, 32'h00001234);
    chk("illegal_err", err, 1);
    step(0, 0, 0, 1, 0, 0);

    step(1, 16'h00AA, 3'd0, 0, 0, 0);
    step(1, 16'h00BB, 3'd0, 0, 0, 0);
    step(1, 16'h00CC, 3'd0, 0, 1, 0);
    chk("flush_valid", out_valid, 0);
    chk("flush_ready", in_ready, 1);
    chk("flush_err", err, 1);
    step(0, 0, 0, 1, 0, 0);
    chk("flush_gone", out_valid, 0);
    step(0, 0, 0, 1, 0, 1);
    chk("reset_err", err, 0);

    reset2 = 0;
    in_valid2 = 1; in_imm2 = 12'h800; in_op2 = 3'd1;
    @(posedge clk); #1;
    chk("w12_valid", out_valid2, 1);
    chk("w12_sext", out_data2, 24'hFFF800);
    in_imm2 = 12'h123; in_op2 = 3'd7; reset2 = 1;
    @(posedge clk); #1;
    chk("w12_rst_valid", out_valid2, 0);
    chk("w12_rst_data", out_data2, 24'h0);
    chk("w12_rst_ready", in_ready2, 1);
    chk("w12_rst_err", err2, 0);
    in_valid2 = 0;

    for (int i = 0; i < 1500; i++) begin
      step($urandom_range(0, 3) != 0,
           16'($urandom),
           3'($urandom_range(0, 7)),
           $urandom_range(0, 2) != 0,
           $urandom_range(0, 40) == 0,
           $urandom_range(0, 150) == 0);
    end
    step(0, 0, 0, 1, 0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/imm_ext_pipe.md
# imm_ext_pipe

Parametrised, pipelined immediate extender for the pipelined datapath. Accepts an IN_W-bit immediate plus a 3-bit extension opcode through a valid/ready handshake and presents the OUT_W-bit result one cycle later through a registered output stage. A 2-entry skid buffer gives full throughput under downstream back-pressure. Supports flush and a sticky illegal-opcode flag. Sits between the decode register and the ID/EX pipeline register.

## Interface
- IN_W, 16, immediate input width; must satisfy 1 ≤ IN_W ≤ OUT_W-2.
- OUT_W, 32, extended output width.
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- flush  in  1  synchronous pipeline flush; discards all held entries.
- in_valid  in  1  upstream holds a valid immediate/opcode.
- in_ready  out  1  block can accept this cycle.
- in_imm  in  IN_W  raw immediate I.
- in_op  in  3  extension opcode.
- out_valid  out  1  out_data is valid.
- out_ready  in  1  downstream accepts this cycle.
- out_data  out  OUT_W  extended result.
- out_op  out  3  opcode that produced out_data.
- err  out  1  sticky: an illegal opcode was accepted since last reset.

## Operation
- Opcodes, with Z = OUT_W-IN_W:
  - 000: zero-extend, {Z zeros, I}.
  - 001: sign-extend, {Z copies of I[IN_W-1], I}.
  - 010: upper-load, I placed at the top: (I << Z), low Z bits zero; when IN_W=16 and OUT_W=32 this is {I, 16'h0000}.
  - 011: branch offset, sign-extend then shift left 2, truncated to OUT_W.
  - 100: zero-extend then shift left 2, truncated to OUT_W.
  - 101–111: illegal. Result is the zero-extend, and err is set on the accepting edge.
- Accept: in_valid && in_ready && !flush. The result is computed combinationally and written into the output register, or into the skid register if the output register is occupied and not draining.
- Storage is two entries. The main output register drives out_data, out_op and out_valid. The skid register is internal.
- in_ready = !skid_valid, driven from a register, with no combinational path from out_ready.
- Drain: out_valid && out_ready. If the skid register is full, the skid entry moves to the output register. Otherwise the output register takes the new accept, or clears.
- Ordering is strict FIFO; results never reorder or duplicate.
- Simultaneous drain and accept with the skid register empty: the output register loads the new result and out_valid stays 1.
- Simultaneous drain and accept with the skid register full: cannot occur, because in_ready is 0.
- Output register full, no drain, and an accept: the result goes to the skid register and in_ready drops the next cycle.
- flush: on the edge, out_valid and skid_valid go to 0 and no input is accepted that cycle. in_ready is 1 the next cycle. err is unaffected.
- reset has priority over flush.
- Reset values: out_valid=0, out_data=0, out_op=000, in_ready=1, skid cleared, err=0.
- A reset asserted mid-transfer discards any held entries and returns the block to the reset values on that edge.

## Timing
- Latency is 1 cycle from the accept edge to out_valid=1 with the corresponding out_data.
- Throughput is 1 result per cycle while out_ready=1.
- Back-pressure: the block absorbs exactly 2 results before in_ready=0.
- When out_ready rises, the skid entry appears on out_data the next cycle, and in_ready=1 that same next cycle.
- out_data and out_op remain stable while out_valid=1 and out_ready=0.
- err asserts the cycle after the illegal accept and holds until reset.

## Test plan
- Default params, op=000/001/010, in_imm=16'h8001, out_ready=1 → out_data=32'h00008001, 32'hFFFF8001, 32'h80010000 on consecutive cycles, one cycle after each accept.
- op=011 with in_imm=16'hFFFF → 32'hFFFFFFFC; op=100 with in_imm=16'hFFFF → 32'h0003FFFC.
- out_ready=0 while streaming 16'h0001, 0002, 0003 → only 0001 and 0002 are accepted and in_ready=0. Then out_ready=1 → outputs 0001, 0002, 0003 in order, with no gaps or duplicates.
- op=110 with in_imm=16'h1234 → out_data=32'h00001234 and err=1 from the next cycle. err stays 1 through a flush and clears only on reset.
- With both entries full, assert flush together with in_valid=1 → next cycle out_valid=0 and in_ready=1, and the flushed input never appears.
- IN_W=12, OUT_W=24, op=001 with in_imm=12'h800 → 24'hFFF800. Then assert reset mid-stream → all outputs take their reset values the next cycle.
